// File: rtl/cpu6_core.sv
// rtl/cpu6_core.sv - 6-bit accumulator CPU on the 8-bit I/O pin bundle (optional SUB via CPU6_SUB_EN)
module cpu6_core (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SWAP  = 6'd2;
    localparam logic [5:0] OP_MOVCA = 6'd3;
    localparam logic [5:0] OP_MOVAC = 6'd4;
    localparam logic [5:0] OP_JMP   = 6'd5;
    localparam logic [5:0] OP_JZ    = 6'd6;
    localparam logic [5:0] OP_LI    = 6'd7;
    localparam logic [5:0] OP_SUB   = 6'd8;
    localparam logic [5:0] OP_OUT   = 6'd16;

    logic       clk;
    logic       rst_n;
    logic [5:0] mem_data;

    assign clk      = io_in[0];
    assign rst_n    = io_in[1];
    assign mem_data = io_in[7:2];

    state_t     micro_pc;
    logic [5:0] reg_a;
    logic [5:0] reg_b;
    logic [5:0] reg_c;
    logic [5:0] pc;
    logic [5:0] instr;
    logic       out_exec;

    // Output depends on state only, so the external memory never closes a loop.
    assign out_exec = (micro_pc == EXEC) && (instr == OP_OUT);
    assign io_out   = {out_exec, 1'b0, out_exec ? reg_a : pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            micro_pc <= FETCH;
            reg_a    <= 6'd0;
            reg_b    <= 6'd1;
            reg_c    <= 6'd0;
            pc       <= 6'd0;
            instr    <= 6'd0;
        end else begin
            case (micro_pc)
                FETCH: begin
                    instr    <= mem_data;
                    pc       <= pc + 6'd1;
                    micro_pc <= EXEC;
                end
                EXEC: begin
                    micro_pc <= FETCH;
                    case (instr)
                        OP_ADD:   reg_a <= reg_a + reg_b;
                        OP_SWAP: begin
                            reg_a <= reg_b;
                            reg_b <= reg_a;
                        end
                        OP_MOVCA: reg_a <= reg_c;
                        OP_MOVAC: reg_c <= reg_a;
                        OP_JMP:   pc    <= mem_data;
                        // pc already points at the operand word; skip it when not taken.
                        OP_JZ:    pc    <= (reg_a == 6'd0) ? mem_data : pc + 6'd1;
                        OP_LI: begin
                            reg_a <= mem_data;
                            pc    <= pc + 6'd1;
                        end
`ifdef CPU6_SUB_EN
                        OP_SUB:   reg_a <= reg_a - reg_b;
`endif
                        default: ;
                    endcase
                end
                default: micro_pc <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_core.sv
// tb/tb_cpu6_core.sv - directed self-checking bench for cpu6_core with strobe scoreboard
module tb_cpu6_core;

    logic       clk;
    logic       rst_n;
    logic [5:0] mem [0:63];
    logic [7:0] io_in;
    logic [7:0] io_out;

    int passed;
    int total;
    logic [5:0] sb [$];

    assign io_in = {mem[io_out[5:0]], rst_n, clk};

    cpu6_core dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 6'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance n edges; every strobe seen is matched against the scoreboard.
    task automatic run(input int n);
        logic [5:0] exp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (io_out[7]) begin
                if (sb.size() == 0) begin
                    check("strobe_unexpected", io_out, 8'h00);
                end else begin
                    exp = sb.pop_front();
                    check("strobe_data", {2'b00, io_out[5:0]}, {2'b00, exp});
                end
            end
        end
    endtask

    initial begin
        logic [7:0] sub_exp;
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        clear_mem();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("io_out_in_reset", io_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_a", {2'b00, dut.reg_a}, 8'd0);
        check("reset_b", {2'b00, dut.reg_b}, 8'd1);
        check("reset_c", {2'b00, dut.reg_c}, 8'd0);
        check("reset_fetch_addr", io_out, 8'h00);

        // Program run
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 6'd1;  mem[1] = 6'd2;  mem[2] = 6'd16; mem[3] = 6'd6;
        mem[4] = 6'd0;  mem[5] = 6'd7;  mem[6] = 6'd63; mem[7] = 6'd4;
        mem[8] = 6'd1;  mem[9] = 6'd3;  mem[10] = 6'd5; mem[11] = 6'd7;
        sb.push_back(6'd1);
        do_reset();
        run(2);
        check("prog_add_a", {2'b00, dut.reg_a}, 8'd1);
        run(2);
        check("prog_swap_b", {2'b00, dut.reg_b}, 8'd1);
        run(1);
        check("prog_out_bus", io_out, 8'h81);
        run(3);
        check("prog_jz_not_taken", io_out, 8'd5);
        run(2);
        check("prog_li_a", {2'b00, dut.reg_a}, 8'd63);
        run(2);
        check("prog_movac_c", {2'b00, dut.reg_c}, 8'd63);
        run(2);
        check("prog_add_wrap", {2'b00, dut.reg_a}, 8'd0);
        run(2);
        check("prog_movca_a", {2'b00, dut.reg_a}, 8'd63);
        run(2);
        check("prog_jmp_target", io_out, 8'd7);
        run(22);
        check("prog_end_a", {2'b00, dut.reg_a}, 8'd63);
        check("prog_end_pc", io_out, 8'd10);
        check("prog_strobes_left", 8'(sb.size()), 8'd0);

        // JZ taken with A=0
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 6'd6; mem[1] = 6'd5;
        do_reset();
        run(2);
        check("jz_taken", io_out, 8'd5);

        // JZ not taken with A=3
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 6'd7; mem[1] = 6'd3; mem[2] = 6'd6; mem[3] = 6'd9;
        do_reset();
        run(4);
        check("jz_not_taken", io_out, 8'd4);

        // pc wrap through a NOP at 63
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 6'd5; mem[1] = 6'd63;
        do_reset();
        run(2);
        check("wrap_at_63", io_out, 8'd63);
        run(2);
        check("wrap_to_0", io_out, 8'd0);

        // Async reset during OUT
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 6'd7; mem[1] = 6'd42; mem[2] = 6'd16;
        sb.push_back(6'd42);
        do_reset();
        run(3);
        check("out_before_reset", io_out, 8'hAA);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_io_out", io_out, 8'h00);
        check("async_reset_a", {2'b00, dut.reg_a}, 8'd0);

        // Opcode 8 (SUB when enabled)
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 6'd7; mem[1] = 6'd5; mem[2] = 6'd2;
        mem[3] = 6'd7; mem[4] = 6'd2; mem[5] = 6'd8;
        do_reset();
        run(6);
        check("sub_pre_b", {2'b00, dut.reg_b}, 8'd5);
        run(2);
`ifdef CPU6_SUB_EN
        sub_exp = 8'd61;
`else
        sub_exp = 8'd2;
`endif
        check("opcode8_a", {2'b00, dut.reg_a}, sub_exp);
        check("opcode8_next_fetch", io_out, 8'd6);
        check("strobes_left_final", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
